// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
// Provides the default widths, the requester tag type and a pointer helper.
package mul_share_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 13;
    localparam int MUL_LAT_DEF = 2;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic                valid;
        logic [ID_W_DEF-1:0] id;
    } req_tag_t;

    // Round-robin successor of a granted index.
    function automatic logic [ID_W_DEF-1:0] next_ptr(
        input logic [ID_W_DEF-1:0] idx,
        input int                  n
    );
        if (int'(idx) == n - 1)
            return '0;
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i.
// Ports: req_i/ptr_i in; one-hot gnt_o, binary idx_o and any_o out.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int j;

    // Walk the search order backwards so the closest request to ptr wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined multiplier between requesters, tagging each result.
// Ports: req_* request side, mul_* multiplier side, res_* result side, busy.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      mul_ce,
    output logic [DATA_W-1:0]         mul_din0,
    output logic [DATA_W-1:0]         mul_din1,
    input  logic [DATA_W-1:0]         mul_dout,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [DATA_W-1:0]         res_data,
    input  logic                      res_ready,
    output logic                      busy
);

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               issue;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    req_tag_t           tag_q [MUL_LAT];
    req_tag_t           tag_d [MUL_LAT];

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign res_valid = tag_q[MUL_LAT-1].valid;
    assign res_id    = tag_q[MUL_LAT-1].id;
    assign res_data  = mul_dout;

    // Pipeline freezes only while an unaccepted result sits at the tail.
    assign mul_ce    = reset_n & ~(res_valid & ~res_ready);
    assign issue     = pick_any & mul_ce;
    assign req_ready = pick_gnt & {NUM_REQ{mul_ce}};

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        if (issue) begin
            mul_din0 = req_a[pick_idx*DATA_W +: DATA_W];
            mul_din1 = req_b[pick_idx*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        ptr_d          = issue ? next_ptr(pick_idx, NUM_REQ) : ptr_q;
        tag_d[0].valid = issue;
        tag_d[0].id    = issue ? pick_idx : '0;
        for (int k = 1; k < MUL_LAT; k++)
            tag_d[k] = tag_q[k-1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            for (int k = 0; k < MUL_LAT; k++)
                tag_q[k] <= '0;
        end else if (mul_ce) begin
            ptr_q <= ptr_d;
            for (int k = 0; k < MUL_LAT; k++)
                tag_q[k] <= tag_d[k];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < MUL_LAT; k++)
            busy = busy | tag_q[k].valid;
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter with a behavioural multiplier.
// Directed test-plan steps followed by a random phase against a queue model.
module tb_mul_share_arbiter;

    localparam int N   = 4;
    localparam int DW  = 13;
    localparam int LAT = 2;
    localparam int IW  = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_a, req_b;
    logic [N-1:0]    req_ready;
    logic            mul_ce;
    logic [DW-1:0]   mul_din0, mul_din1, mul_dout;
    logic            res_valid;
    logic [IW-1:0]   res_id;
    logic [DW-1:0]   res_data;
    logic            res_ready;
    logic            busy;

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .MUL_LAT (LAT),
        .ID_W    (IW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy)
    );

    // Behavioural pipelined multiplier with clock enable, no reset.
    logic signed [2*DW-1:0] full;
    logic [DW-1:0]          pipe [LAT];
    assign full     = $signed(mul_din0) * $signed(mul_din1);
    assign mul_dout = pipe[LAT-1];

    always_ff @(posedge clk) begin
        if (mul_ce) begin
            pipe[0] <= full[DW-1:0];
            for (int k = 1; k < LAT; k++)
                pipe[k] <= pipe[k-1];
        end
    end

    // Reference model: in-flight operations with their ce-edge age.
    typedef struct {
        int            id;
        logic [DW-1:0] prod;
        int            age;
    } op_t;

    op_t           q[$];
    int            m_ptr;
    int            exp_g;
    logic          fv;
    logic          exp_ce;
    logic          va [N];
    logic [DW-1:0] ra [N];
    logic [DW-1:0] rb [N];
    int            n_checks = 0;
    int            n_err    = 0;

    function automatic logic [DW-1:0] prod(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        int          p;
        logic [31:0] pv;
        p  = int'($signed(a)) * int'($signed(b));
        pv = p;
        return pv[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = va[i];
            req_a[i*DW +: DW]   = ra[i];
            req_b[i*DW +: DW]   = rb[i];
        end
    endtask

    // Drive inputs, move to mid-cycle and compare against the model.
    task automatic half();
        logic [N-1:0]  eg;
        logic [DW-1:0] e0, e1;
        pack();
        #4;
        fv     = (q.size() > 0) && (q[0].age == LAT);
        exp_ce = reset_n && !(fv && !res_ready);
        exp_g  = -1;
        if (exp_ce) begin
            for (int k = N - 1; k >= 0; k--)
                if (va[(m_ptr + k) % N])
                    exp_g = (m_ptr + k) % N;
        end
        eg = '0;
        e0 = '0;
        e1 = '0;
        if (exp_g >= 0) begin
            eg[exp_g] = 1'b1;
            e0        = ra[exp_g];
            e1        = rb[exp_g];
        end
        chk("mul_ce", 32'(mul_ce), 32'(exp_ce));
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("mul_din0", 32'(mul_din0), 32'(e0));
        chk("mul_din1", 32'(mul_din1), 32'(e1));
        chk("res_valid", 32'(res_valid), 32'(fv));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        if (fv) begin
            chk("res_id", 32'(res_id), 32'(q[0].id));
            chk("res_data", 32'(res_data), 32'(q[0].prod));
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        if (reset_n && exp_ce) begin
            if (fv && res_ready)
                void'(q.pop_front());
            foreach (q[k])
                q[k].age++;
            if (exp_g >= 0) begin
                q.push_back('{id: exp_g,
                              prod: prod(ra[exp_g], rb[exp_g]),
                              age: 1});
                m_ptr     = (exp_g + 1) % N;
                va[exp_g] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic cyc(input int n);
        for (int c = 0; c < n; c++) begin
            half();
            edge_step();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        m_ptr = 0;
        cyc(2);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        res_ready = 1'b1;
        m_ptr     = 0;
        for (int i = 0; i < N; i++) begin
            va[i] = 1'b0;
            ra[i] = '0;
            rb[i] = '0;
        end
        pack();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ce", 32'(mul_ce), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        half();
        chk("post_rst_ce", 32'(mul_ce), 32'd1);
        edge_step();

        // Single request from requester 2.
        va[2] = 1'b1;
        ra[2] = 13'd5;
        rb[2] = 13'h1FFD;
        half();
        chk("single_rdy", 32'(req_ready), 32'h4);
        edge_step();
        half();
        chk("single_rdy_off", 32'(req_ready), 32'h0);
        edge_step();
        half();
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_id", 32'(res_id), 32'd2);
        chk("single_data", 32'(res_data), 32'h1FF1);
        edge_step();
        half();
        chk("single_idle", 32'(busy), 32'd0);
        edge_step();

        // Fairness with everyone requesting.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!va[i]) begin
                    va[i] = 1'b1;
                    ra[i] = DW'($urandom);
                    rb[i] = DW'($urandom);
                end
            end
            half();
            chk("fair_gnt", 32'(req_ready), 32'(1 << (k % N)));
            if (k >= 2) begin
                chk("fair_valid", 32'(res_valid), 32'd1);
                chk("fair_id", 32'(res_id), 32'((k - 2) % N));
            end
            edge_step();
        end
        for (int i = 0; i < N; i++)
            va[i] = 1'b0;
        cyc(4);

        // Back-pressure: three issues, then five stalled cycles.
        for (int i = 0; i < 3; i++)
            va[i] = 1'b1;
        ra[0] = 13'd3;
        rb[0] = 13'd4;
        ra[1] = 13'h1FEC;
        rb[1] = 13'd11;
        ra[2] = 13'd50;
        rb[2] = 13'd2;
        cyc(3);
        res_ready = 1'b0;
        va[3]     = 1'b1;
        ra[3]     = 13'd7;
        rb[3]     = 13'd7;
        for (int k = 0; k < 5; k++) begin
            half();
            chk("bp_ce", 32'(mul_ce), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_id", 32'(res_id), 32'd1);
            chk("bp_data", 32'(res_data), 32'h1F24);
            edge_step();
        end
        res_ready = 1'b1;
        cyc(6);
        chk("bp_drained", 32'(busy), 32'd0);

        // Sparse load pointer fairness.
        va[3] = 1'b1;
        half();
        chk("sparse_3", 32'(req_ready), 32'h8);
        edge_step();
        va[1] = 1'b1;
        va[3] = 1'b1;
        half();
        chk("sparse_1", 32'(req_ready), 32'h2);
        edge_step();
        half();
        chk("sparse_3b", 32'(req_ready), 32'h8);
        edge_step();
        cyc(3);

        // Wrap-around of the truncated product.
        va[0] = 1'b1;
        ra[0] = 13'd100;
        rb[0] = 13'd100;
        cyc(2);
        half();
        chk("wrap_pos", 32'(res_data), 32'd1808);
        edge_step();
        va[1] = 1'b1;
        ra[1] = 13'h1000;
        rb[1] = 13'h1FFF;
        cyc(2);
        half();
        chk("wrap_neg", 32'(res_data), 32'h1000);
        edge_step();
        cyc(2);

        // Reset while an operation is in flight.
        va[1] = 1'b1;
        ra[1] = 13'd9;
        rb[1] = 13'd9;
        cyc(1);
        reset_n = 1'b0;
        q.delete();
        m_ptr = 0;
        #1;
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(3);
        va[0] = 1'b1;
        va[3] = 1'b1;
        half();
        chk("midrst_gnt0", 32'(req_ready), 32'h1);
        edge_step();
        cyc(4);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!va[i] && $urandom_range(0, 2) == 0) begin
                    va[i] = 1'b1;
                    ra[i] = DW'($urandom);
                    rb[i] = DW'($urandom);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        for (int i = 0; i < N; i++)
            va[i] = 1'b0;
        res_ready = 1'b1;
        cyc(8);
        chk("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
